rdma_tx_pkt_arbiter: RTL and testbench

//  Packet-atomic scheduler that shares the single CMAC TX AXI-Stream between two requesters:
//  the RDMA engine (xrnic TX) and the host DMA TX path. It is the egress counterpart of the RX

---
 rtl/rdma_tx_arb_pkg.sv | 18 +
 rtl/axis_out_reg.sv | 70 +++++++
 rtl/rdma_tx_pkt_arbiter.sv | 145 ++++++++++++++
 tb/tb_rdma_tx_pkt_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_tx_arb_pkg.sv
// Shared types for the RDMA/DMA TX packet arbiter: FSM state encoding and source ids.
package rdma_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_RDMA = 2'd1,
    GNT_DMA  = 2'd2
  } arb_state_t;

  localparam logic SRC_RDMA = 1'b0;
  localparam logic SRC_DMA  = 1'b1;

  // Saturating 4-bit increment used for the RDMA burst counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] limit);
    return (val < limit) ? val + 4'd1 : limit;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream pipeline register (data/keep/last/user/valid) with ready passed through.
module axis_out_reg #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [KEEP_W-1:0] in_tkeep,
  input  logic              in_tlast,
  input  logic              in_tuser,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic [KEEP_W-1:0] out_tkeep,
  output logic              out_tlast,
  output logic              out_tuser,
  output logic              out_tvalid,
  input  logic              out_tready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;
  logic              user_q, user_d;

  assign in_tready = !valid_q || out_tready;

  // Payload only changes on a load, so it stays stable while the sink stalls.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    user_d  = user_q;
    if (in_tvalid && in_tready) begin
      valid_d = 1'b1;
      data_d  = in_tdata;
      keep_d  = in_tkeep;
      last_d  = in_tlast;
      user_d  = in_tuser;
    end else if (out_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign out_tdata  = data_q;
  assign out_tkeep  = keep_q;
  assign out_tlast  = last_q;
  assign out_tuser  = user_q;
  assign out_tvalid = valid_q;

endmodule

// File: rtl/rdma_tx_pkt_arbiter.sv
// Packet-atomic CMAC TX arbiter between RDMA and host DMA, RDMA preferred with a DMA slot guaranteed.
// Optional packet counters built when RDMA_TX_ARB_STATS_EN is defined.
module rdma_tx_pkt_arbiter
  import rdma_tx_arb_pkg::*;
#(
  parameter int DATA_W         = 512,
  parameter int KEEP_W         = 64,
  parameter int RDMA_BURST_MAX = 4
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic [DATA_W-1:0] s_rdma_axis_tdata,
  input  logic [KEEP_W-1:0] s_rdma_axis_tkeep,
  input  logic              s_rdma_axis_tlast,
  input  logic              s_rdma_axis_tuser,
  input  logic              s_rdma_axis_tvalid,
  output logic              s_rdma_axis_tready,
  input  logic [DATA_W-1:0] s_dma_axis_tdata,
  input  logic [KEEP_W-1:0] s_dma_axis_tkeep,
  input  logic              s_dma_axis_tlast,
  input  logic              s_dma_axis_tuser,
  input  logic              s_dma_axis_tvalid,
  output logic              s_dma_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              cur_src,
  output logic              arb_busy,
  output logic [31:0]       stat_rdma_pkts,
  output logic [31:0]       stat_dma_pkts
);

  localparam logic [3:0] BURST_MAX = 4'(RDMA_BURST_MAX);

  arb_state_t        state_q, state_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              sel_dma;
  logic              sel_tvalid;
  logic              sel_tlast;
  logic              sel_tuser;
  logic [DATA_W-1:0] sel_tdata;
  logic [KEEP_W-1:0] sel_tkeep;
  logic              reg_ready;
  logic              beat_accept;

  assign sel_dma    = (state_q == GNT_DMA);
  assign sel_tvalid = (state_q != IDLE) && (sel_dma ? s_dma_axis_tvalid : s_rdma_axis_tvalid);
  assign sel_tdata  = sel_dma ? s_dma_axis_tdata : s_rdma_axis_tdata;
  assign sel_tkeep  = sel_dma ? s_dma_axis_tkeep : s_rdma_axis_tkeep;
  assign sel_tlast  = sel_dma ? s_dma_axis_tlast : s_rdma_axis_tlast;
  assign sel_tuser  = sel_dma ? s_dma_axis_tuser : s_rdma_axis_tuser;

  assign s_rdma_axis_tready = (state_q == GNT_RDMA) && reg_ready;
  assign s_dma_axis_tready  = (state_q == GNT_DMA) && reg_ready;
  assign beat_accept        = sel_tvalid && reg_ready;

  assign arb_busy = (state_q != IDLE);
  assign cur_src  = sel_dma ? SRC_DMA : SRC_RDMA;

  // Grant decision is only made in IDLE; a grant is held until its tlast beat is accepted.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_rdma_axis_tvalid && (!s_dma_axis_tvalid || burst_cnt_q < BURST_MAX)) begin
          state_d     = GNT_RDMA;
          burst_cnt_d = sat_inc4(burst_cnt_q, BURST_MAX);
        end else if (s_dma_axis_tvalid) begin
          state_d     = GNT_DMA;
          burst_cnt_d = '0;
        end
      end
      GNT_RDMA, GNT_DMA: begin
        if (beat_accept && sel_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  axis_out_reg #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W)
  ) u_out_reg (
    .clk        (core_clk),
    .rst_n      (core_rst),
    .in_tdata   (sel_tdata),
    .in_tkeep   (sel_tkeep),
    .in_tlast   (sel_tlast),
    .in_tuser   (sel_tuser),
    .in_tvalid  (sel_tvalid),
    .in_tready  (reg_ready),
    .out_tdata  (m_axis_tdata),
    .out_tkeep  (m_axis_tkeep),
    .out_tlast  (m_axis_tlast),
    .out_tuser  (m_axis_tuser),
    .out_tvalid (m_axis_tvalid),
    .out_tready (m_axis_tready)
  );

`ifdef RDMA_TX_ARB_STATS_EN
  logic [31:0] stat_rdma_q, stat_rdma_d;
  logic [31:0] stat_dma_q, stat_dma_d;

  // Counted on the accepted tlast beat; wraps naturally at 2^32.
  always_comb begin
    stat_rdma_d = stat_rdma_q;
    stat_dma_d  = stat_dma_q;
    if (beat_accept && sel_tlast) begin
      if (sel_dma) stat_dma_d  = stat_dma_q + 32'd1;
      else         stat_rdma_d = stat_rdma_q + 32'd1;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      stat_rdma_q <= '0;
      stat_dma_q  <= '0;
    end else begin
      stat_rdma_q <= stat_rdma_d;
      stat_dma_q  <= stat_dma_d;
    end
  end

  assign stat_rdma_pkts = stat_rdma_q;
  assign stat_dma_pkts  = stat_dma_q;
`else
  assign stat_rdma_pkts = 32'h0;
  assign stat_dma_pkts  = 32'h0;
`endif

endmodule

// File: tb/tb_rdma_tx_pkt_arbiter.sv
// Self-checking bench for rdma_tx_pkt_arbiter: random traffic against a packet-level model
// plus directed literal checks for latency, grant order, reset and packet counters.
module tb_rdma_tx_pkt_arbiter;

  localparam int DW    = 512;
  localparam int KW    = 64;
  localparam int BURST = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct {
    logic mv;
    logic ml;
    logic busy;
    logic src;
  } obs_t;

  logic          core_clk = 1'b0;
  logic          core_rst;
  logic [DW-1:0] drv_data [2];
  logic [KW-1:0] drv_keep [2];
  logic          drv_last [2];
  logic          drv_user [2];
  logic          drv_valid[2];
  logic          s_rdma_axis_tready, s_dma_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tuser, m_axis_tvalid;
  logic          m_axis_tready;
  logic          cur_src, arb_busy;
  logic [31:0]   stat_rdma_pkts, stat_dma_pkts;

  int n_cmp = 0;
  int n_mis = 0;

  // stimulus generator state, index 0 = RDMA, 1 = DMA
  int   gen_active[2];
  int   gen_len[2];
  int   gen_idx[2];
  int   quota[2];
  logic acc[2];
  obs_t obs[$];

  // behavioural model: grant owner (-1 none), consecutive RDMA grants, output slot, packet counts
  int          mdl_grant;
  int          mdl_streak;
  beat_t       mdl_out[$];
  logic [31:0] mdl_pkts[2];

  always #5 core_clk = ~core_clk;

  rdma_tx_pkt_arbiter #(
    .DATA_W(DW), .KEEP_W(KW), .RDMA_BURST_MAX(BURST)
  ) dut (
    .core_clk          (core_clk),
    .core_rst          (core_rst),
    .s_rdma_axis_tdata (drv_data[0]),
    .s_rdma_axis_tkeep (drv_keep[0]),
    .s_rdma_axis_tlast (drv_last[0]),
    .s_rdma_axis_tuser (drv_user[0]),
    .s_rdma_axis_tvalid(drv_valid[0]),
    .s_rdma_axis_tready(s_rdma_axis_tready),
    .s_dma_axis_tdata  (drv_data[1]),
    .s_dma_axis_tkeep  (drv_keep[1]),
    .s_dma_axis_tlast  (drv_last[1]),
    .s_dma_axis_tuser  (drv_user[1]),
    .s_dma_axis_tvalid (drv_valid[1]),
    .s_dma_axis_tready (s_dma_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .cur_src           (cur_src),
    .arb_busy          (arb_busy),
    .stat_rdma_pkts    (stat_rdma_pkts),
    .stat_dma_pkts     (stat_dma_pkts)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_stat(input logic [31:0] cnt);
`ifdef RDMA_TX_ARB_STATS_EN
    return cnt;
`else
    return (cnt & 32'h0);
`endif
  endfunction

  task automatic clearGens();
    for (int s = 0; s < 2; s++) begin
      gen_active[s] = 0;
      gen_len[s]    = 0;
      gen_idx[s]    = 0;
      quota[s]      = 0;
      drv_valid[s]  = 1'b0;
      drv_data[s]   = '0;
      drv_keep[s]   = '0;
      drv_last[s]   = 1'b0;
      drv_user[s]   = 1'b0;
    end
  endtask

  // Runs n cycles: samples handshakes at negedge, then updates sources and sink ready after posedge.
  task automatic applyStimulus(input int n, input int rpct, input int dpct, input int mpct,
                               input int fixed_len);
    int pct[2];
    pct[0] = rpct;
    pct[1] = dpct;
    for (int c = 0; c < n; c++) begin
      @(negedge core_clk);
      acc[0] = drv_valid[0] && s_rdma_axis_tready;
      acc[1] = drv_valid[1] && s_dma_axis_tready;
      obs.push_back('{mv: m_axis_tvalid, ml: m_axis_tlast, busy: arb_busy, src: cur_src});
      @(posedge core_clk);
      #1;
      for (int s = 0; s < 2; s++) begin
        if (!(drv_valid[s] && !acc[s])) begin
          if (acc[s]) begin
            if (drv_last[s]) gen_active[s] = 0;
            else gen_idx[s]++;
          end
          if ((gen_active[s] != 0 || quota[s] > 0) && ($urandom_range(99) < pct[s])) begin
            if (gen_active[s] == 0) begin
              gen_active[s] = 1;
              quota[s]--;
              gen_len[s] = (fixed_len > 0) ? fixed_len : int'($urandom_range(4, 1));
              gen_idx[s] = 0;
            end
            for (int w = 0; w < DW / 32; w++) drv_data[s][w*32 +: 32] = $urandom();
            drv_keep[s]  = {$urandom(), $urandom()};
            drv_user[s]  = 1'($urandom_range(1, 0));
            drv_last[s]  = (gen_idx[s] == gen_len[s] - 1);
            drv_valid[s] = 1'b1;
          end else begin
            drv_valid[s] = 1'b0;
          end
        end
      end
      m_axis_tready = ($urandom_range(99) < mpct);
    end
  endtask

  task automatic doReset();
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    clearGens();
    repeat (2) @(posedge core_clk);
    #1;
    core_rst = 1'b1;
  endtask

  // Compare process: check DUT against the model, then advance the model with this cycle's inputs.
  always @(negedge core_clk) begin
    logic  exp_rdy[2];
    beat_t in_beat;
    int    pick;
    if (!core_rst) begin
      mdl_grant  = -1;
      mdl_streak = 0;
      mdl_out.delete();
      mdl_pkts[0] = '0;
      mdl_pkts[1] = '0;
      checkOutput("rst_mvalid", 512'(m_axis_tvalid), 512'(0));
      checkOutput("rst_mdata", m_axis_tdata, '0);
      checkOutput("rst_busy", 512'(arb_busy), 512'(0));
      checkOutput("rst_rdy", 512'({s_rdma_axis_tready, s_dma_axis_tready}), 512'(0));
    end else begin
      exp_rdy[0] = (mdl_grant == 0) && (mdl_out.size() == 0 || m_axis_tready);
      exp_rdy[1] = (mdl_grant == 1) && (mdl_out.size() == 0 || m_axis_tready);
      checkOutput("rdma_tready", 512'(s_rdma_axis_tready), 512'(exp_rdy[0]));
      checkOutput("dma_tready", 512'(s_dma_axis_tready), 512'(exp_rdy[1]));
      checkOutput("arb_busy", 512'(arb_busy), 512'(mdl_grant >= 0));
      if (mdl_grant >= 0) checkOutput("cur_src", 512'(cur_src), 512'(mdl_grant == 1));
      checkOutput("m_tvalid", 512'(m_axis_tvalid), 512'(mdl_out.size() != 0));
      if (mdl_out.size() != 0) begin
        checkOutput("m_tdata", m_axis_tdata, mdl_out[0].data);
        checkOutput("m_tkeep", 512'(m_axis_tkeep), 512'(mdl_out[0].keep));
        checkOutput("m_tlast", 512'(m_axis_tlast), 512'(mdl_out[0].last));
        checkOutput("m_tuser", 512'(m_axis_tuser), 512'(mdl_out[0].user));
      end
      checkOutput("stat_rdma", 512'(stat_rdma_pkts), 512'(exp_stat(mdl_pkts[0])));
      checkOutput("stat_dma", 512'(stat_dma_pkts), 512'(exp_stat(mdl_pkts[1])));

      if (mdl_out.size() != 0 && m_axis_tready) void'(mdl_out.pop_front());
      if (mdl_grant < 0) begin
        if (drv_valid[0] || drv_valid[1]) begin
          if (drv_valid[0] && drv_valid[1]) pick = (mdl_streak >= BURST) ? 1 : 0;
          else pick = drv_valid[0] ? 0 : 1;
          if (pick == 0) mdl_streak = (mdl_streak < BURST) ? mdl_streak + 1 : BURST;
          else mdl_streak = 0;
          mdl_grant = pick;
        end
      end else if (exp_rdy[mdl_grant] && drv_valid[mdl_grant]) begin
        in_beat.data = drv_data[mdl_grant];
        in_beat.keep = drv_keep[mdl_grant];
        in_beat.last = drv_last[mdl_grant];
        in_beat.user = drv_user[mdl_grant];
        mdl_out.push_back(in_beat);
        if (in_beat.last) begin
          mdl_pkts[mdl_grant] = mdl_pkts[mdl_grant] + 32'd1;
          mdl_grant = -1;
        end
      end
    end
  end

  initial begin
    int grants[$];
    int exp_order[10];
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    core_rst      = 1'b0;
    m_axis_tready = 1'b0;
    clearGens();
    repeat (3) @(posedge core_clk);
    #1;
    core_rst = 1'b1;
    checkOutput("post_rst_busy", 512'(arb_busy), 512'(0));
    checkOutput("post_rst_stat", 512'({stat_rdma_pkts, stat_dma_pkts}), 512'(0));

    // DMA alone, one 3-beat packet, sink always ready
    $display("[TB] single DMA packet");
    obs.delete();
    quota[1] = 1;
    applyStimulus(7, 0, 100, 100, 3);
    checkOutput("t1_len", 512'(obs.size()), 512'(7));
    if (obs.size() == 7) begin
      checkOutput("t1_idle_cycle", 512'(obs[1].busy), 512'(0));
      checkOutput("t1_grant", 512'({obs[2].busy, obs[2].src}), 512'(2'b11));
      checkOutput("t1_mvalid", 512'({obs[2].mv, obs[3].mv, obs[4].mv, obs[5].mv, obs[6].mv}),
                  512'(5'b01110));
      checkOutput("t1_mlast", 512'({obs[3].ml, obs[4].ml, obs[5].ml}), 512'(3'b001));
      checkOutput("t1_back_idle", 512'(obs[5].busy), 512'(0));
    end

    // both sources always valid with single-beat packets: R,R,R,R,D repeating
    $display("[TB] grant order");
    doReset();
    obs.delete();
    quota[0] = 100;
    quota[1] = 100;
    applyStimulus(24, 100, 100, 100, 1);
    for (int k = 1; k < obs.size(); k++)
      if (obs[k].busy && !obs[k-1].busy) grants.push_back(int'(obs[k].src));
    checkOutput("t2_grant_count", 512'(grants.size() >= 10), 512'(1));
    for (int k = 0; k < 10 && k < grants.size(); k++)
      checkOutput($sformatf("t2_grant%0d", k), 512'(grants[k]), 512'(exp_order[k]));

    // random traffic, with and without sink back-pressure
    $display("[TB] random traffic");
    doReset();
    quota[0] = 100000;
    quota[1] = 100000;
    applyStimulus(3000, 60, 60, 75, 0);
    applyStimulus(3000, 85, 40, 30, 0);
    applyStimulus(2000, 100, 100, 90, 0);

    // reset asserted while beat 2 of a 4-beat RDMA packet is in flight
    $display("[TB] reset mid-packet");
    doReset();
    quota[0] = 1;
    applyStimulus(4, 100, 0, 100, 4);
    checkOutput("t5_pre_mvalid", 512'(m_axis_tvalid), 512'(1));
    core_rst = 1'b0;
    #1;
    checkOutput("t5_async_mvalid", 512'(m_axis_tvalid), 512'(0));
    checkOutput("t5_async_busy", 512'(arb_busy), 512'(0));
    clearGens();
    repeat (2) @(posedge core_clk);
    #1;
    core_rst = 1'b1;
    #1;
    checkOutput("t5_rel_busy", 512'(arb_busy), 512'(0));
    checkOutput("t5_rel_stats", 512'({stat_rdma_pkts, stat_dma_pkts}), 512'(0));

    // 3 RDMA + 2 DMA packets, then counters
    $display("[TB] packet counters");
    quota[0] = 3;
    quota[1] = 2;
    applyStimulus(150, 80, 80, 70, 2);
    checkOutput("t6_all_sent", 512'(quota[0] + quota[1] + gen_active[0] + gen_active[1]), 512'(0));
    applyStimulus(4, 0, 0, 100, 2);
    checkOutput("t6_model_rdma", 512'(mdl_pkts[0]), 512'(3));
    checkOutput("t6_model_dma", 512'(mdl_pkts[1]), 512'(2));
`ifdef RDMA_TX_ARB_STATS_EN
    checkOutput("t6_stat_rdma", 512'(stat_rdma_pkts), 512'(3));
    checkOutput("t6_stat_dma", 512'(stat_dma_pkts), 512'(2));
`else
    checkOutput("t6_stat_rdma", 512'(stat_rdma_pkts), 512'(0));
    checkOutput("t6_stat_dma", 512'(stat_dma_pkts), 512'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
